// File: rtl/fu_handshake_wrapper.sv
// rtl/fu_handshake_wrapper.sv - ready/valid/padv responder around a fixed-latency pipelined core
//
// Takes one operand at a time from the producer and launches it into the core.
// It then counts the core latency, captures the result and holds it until the
// consumer pulses padv_i.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   padv_i        consumer has taken data_o; return to idle
//   valid_i       operand strobe, accepted only while ready_o=1
//   data_i        operand
//   ready_o       wrapper idle, operand may be presented
//   data_o        captured core result
//   valid_o       data_o valid, held until padv_i
//   core_op_o     operand to core, stable for the whole transaction
//   core_valid_o  one-cycle launch strobe to core
//   core_res_i    core result, valid LATENCY cycles after core_valid_o
//   err_o         sticky protocol-violation flag (only with FU_WRAPPER_ERR_EN)
//
// Optional build macro: FU_WRAPPER_ERR_EN adds err_o.
module fu_handshake_wrapper #(
    parameter int DW      = 16,
    parameter int LATENCY = 4,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          padv_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic [DW-1:0] core_op_o,
    output logic          core_valid_o,
    input  logic [DW-1:0] core_res_i
`ifdef FU_WRAPPER_ERR_EN
    ,
    output logic          err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          ready_n;
    logic          valid_n;
    logic [DW-1:0] data_n;
    logic [DW-1:0] op_n;
    logic          core_valid_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_o      <= 1'b1;
            valid_o      <= 1'b0;
            data_o       <= '0;
            core_op_o    <= '0;
            core_valid_o <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            ready_o      <= ready_n;
            valid_o      <= valid_n;
            data_o       <= data_n;
            core_op_o    <= op_n;
            core_valid_o <= core_valid_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        ready_n      = ready_o;
        valid_n      = valid_o;
        data_n       = data_o;
        op_n         = core_op_o;
        core_valid_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_n         = data_i;
                    core_valid_n = 1'b1;
                    ready_n      = 1'b0;
                    cnt_n        = CW'(LATENCY - 1);
                    state_n      = BUSY;
                end
            end
            BUSY: begin
                // The launch cycle itself is not counted: the core result
                // appears LATENCY edges after the strobe is sampled, so the
                // countdown starts once the strobe has dropped.
                if (core_valid_o) begin
                    cnt_n = cnt_q;
                end else if (cnt_q == '0) begin
                    data_n  = core_res_i;
                    valid_n = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // A valid_i arriving together with padv_i is dropped; the
                // producer must re-present once ready_o is seen high.
                if (padv_i) begin
                    valid_n = 1'b0;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
                valid_n = 1'b0;
            end
        endcase
    end

`ifdef FU_WRAPPER_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if ((valid_i && !ready_o) || (padv_i && !valid_o)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fu_handshake_wrapper.sv
// tb/tb_fu_handshake_wrapper.sv - directed self-checking bench for fu_handshake_wrapper
module tb_fu_handshake_wrapper;

    localparam int DW  = 16;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          padv_i;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [DW-1:0] core_op_o;
    logic          core_valid_o;
    logic [DW-1:0] core_res_i;
`ifdef FU_WRAPPER_ERR_EN
    logic          err_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int n_done   = 0;
    logic valid_q = 1'b0;
    logic [DW-1:0] pipe [LAT];

    always #5 clk = ~clk;

    fu_handshake_wrapper #(.DW(DW), .LATENCY(LAT), .CW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .padv_i       (padv_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .core_op_o    (core_op_o),
        .core_valid_o (core_valid_o),
        .core_res_i   (core_res_i)
`ifdef FU_WRAPPER_ERR_EN
        ,
        .err_o        (err_o)
`endif
    );

    // Stub core: operand+1 through a LAT-deep register pipe.
    always @(posedge clk) begin
        pipe[0] <= core_op_o + 16'd1;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_res_i = pipe[LAT-1];

    // Cycle counter and completion counter (rising edges of valid_o).
    always @(posedge clk) begin
        cycle = cycle + 1;
        if (valid_o && !valid_q) n_done = n_done + 1;
        valid_q = valid_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for valid_o; returns number of edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 50) begin
            step();
            n++;
        end
        check("valid_timeout", {31'd0, valid_o}, 32'd1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 50) begin
            step();
            n++;
        end
        check("ready_timeout", {31'd0, ready_o}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int last_acc;
        int acc;
        int done0;
        logic [DW-1:0] op;

        rst = 1'b1; padv_i = 1'b0; valid_i = 1'b0; data_i = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ready",  {31'd0, ready_o}, 32'd1);
        check("rst_valid",  {31'd0, valid_o}, 32'd0);
        check("rst_data",   {16'd0, data_o}, 32'd0);
        check("rst_op",     {16'd0, core_op_o}, 32'd0);
        check("rst_cvalid", {31'd0, core_valid_o}, 32'd0);

        // Basic transaction: accept at T0, result visible after T0+5
        valid_i = 1'b1; data_i = 16'h3F80;
        step();                      // edge T0
        valid_i = 1'b0; data_i = '0;
        check("b_ready0",  {31'd0, ready_o}, 32'd0);
        check("b_cvalid0", {31'd0, core_valid_o}, 32'd1);
        check("b_op",      {16'd0, core_op_o}, 32'h3F80);
        step();                      // T0+1
        check("b_cvalid1", {31'd0, core_valid_o}, 32'd0);
        for (int i = 2; i <= LAT; i++) begin
            step();
            check("b_early_valid", {31'd0, valid_o}, 32'd0);
        end
        step();                      // T0+5
        check("b_valid", {31'd0, valid_o}, 32'd1);
        check("b_data",  {16'd0, data_o}, 32'h3F81);
        for (int i = 0; i < 10; i++) begin
            step();
            check("b_hold_valid", {31'd0, valid_o}, 32'd1);
            check("b_hold_data",  {16'd0, data_o}, 32'h3F81);
        end

        // Advance
        padv_i = 1'b1;
        step();
        padv_i = 1'b0;
        check("adv_valid", {31'd0, valid_o}, 32'd0);
        check("adv_ready", {31'd0, ready_o}, 32'd1);
        check("adv_data",  {16'd0, data_o}, 32'h3F81);

        // Back-to-back sweep
        done0 = n_done;
        last_acc = -1;
        for (int k = 0; k < 256; k++) begin
            op = 16'h8000 + 16'(k);
            wait_ready();
            valid_i = 1'b1; data_i = op;
            step();
            acc = cycle;
            valid_i = 1'b0;
            if (last_acc >= 0) check("sw_spacing", 32'(acc - last_acc), 32'(LAT + 3));
            last_acc = acc;
            wait_valid(n);
            check("sw_latency", 32'(cycle - acc), 32'(LAT + 1));
            check("sw_data", {16'd0, data_o}, {16'd0, op + 16'd1});
            padv_i = 1'b1;
            step();
            padv_i = 1'b0;
        end
        check("sw_count", 32'(n_done - done0), 32'd256);

        // Ignored inputs
        done0 = n_done;
        wait_ready();
        valid_i = 1'b1; data_i = 16'h1234;
        step();
        data_i = 16'hFFFF;           // valid_i stays high through BUSY
        for (int i = 0; i < LAT; i++) begin
            check("ig_op",    {16'd0, core_op_o}, 32'h1234);
            check("ig_ready", {31'd0, ready_o}, 32'd0);
            step();
        end
        wait_valid(n);
        check("ig_data", {16'd0, data_o}, 32'h1235);
        padv_i = 1'b1;               // valid_i and padv_i together in DONE
        step();
        padv_i = 1'b0; valid_i = 1'b0;
        check("ig_ready_back", {31'd0, ready_o}, 32'd1);
        check("ig_valid_back", {31'd0, valid_o}, 32'd0);
        check("ig_op_kept",    {16'd0, core_op_o}, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            check("ig_no_launch", {31'd0, core_valid_o}, 32'd0);
            step();
        end
        check("ig_one_txn", 32'(n_done - done0), 32'd1);

        // Reset mid-operation
        done0 = n_done;
        valid_i = 1'b1; data_i = 16'h4000;
        step();                      // T0
        valid_i = 1'b0;
        step();                      // T0+1
        rst = 1'b1;
        step();                      // T0+2 samples rst
        rst = 1'b0;
        check("mr_ready", {31'd0, ready_o}, 32'd1);
        check("mr_valid", {31'd0, valid_o}, 32'd0);
        check("mr_data",  {16'd0, data_o}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("mr_no_valid", {31'd0, valid_o}, 32'd0);
        end
        check("mr_no_done", 32'(n_done - done0), 32'd0);

`ifdef FU_WRAPPER_ERR_EN
        do_reset();
        check("err_rst", {31'd0, err_o}, 32'd0);
        padv_i = 1'b1;
        step();
        padv_i = 1'b0;
        check("err_set", {31'd0, err_o}, 32'd1);
        valid_i = 1'b1; data_i = 16'h0010;
        step();
        valid_i = 1'b0;
        wait_valid(n);
        padv_i = 1'b1;
        step();
        padv_i = 1'b0;
        check("err_sticky", {31'd0, err_o}, 32'd1);
        do_reset();
        check("err_clear", {31'd0, err_o}, 32'd0);
`else
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fu_handshake_wrapper.md
Name: fu_handshake_wrapper

Overview:
- Responder-side handshake controller placed around a fixed-latency pipelined arithmetic core, such as the bfloat16 exponential datapath.
- Faces the system through the ready_o / valid_i / valid_o / padv_i protocol.
- Captures one operand at a time and launches it into the core.
- Counts the core latency, then captures and holds the result until the consumer pulses padv_i.

Parameters:
- DW, 16: operand/result width (bfloat16).
- LATENCY, 4: core cycles from core_valid_o high to core_res_i valid; legal range 1..255.
- CW, 8: latency counter width; must satisfy 2**CW > LATENCY.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- padv_i  in  1  consumer pulse: result taken, advance.
- valid_i  in  1  producer operand-valid pulse.
- data_i  in  DW  operand.
- ready_o  out  1  wrapper idle, operand may be presented.
- data_o  out  DW  held result.
- valid_o  out  1  data_o valid, held until padv_i.
- core_op_o  out  DW  operand to core, stable from launch until return to IDLE.
- core_valid_o  out  1  one-cycle launch strobe to core.
- core_res_i  in  DW  core result, valid LATENCY cycles after core_valid_o.

Behaviour:
- Clocking and reset:
  - One clock domain. All state is updated on the rising edge of clk.
  - Reset is synchronous and active-high.
  - All outputs are registered.
  - Reset values: ready_o=1, valid_o=0, data_o=0, core_op_o=0, core_valid_o=0, state=IDLE, counter=0.
- IDLE state:
  - ready_o=1, valid_o=0.
  - When valid_i=1 at edge T0, core_op_o<=data_i, core_valid_o<=1, ready_o<=0, counter<=LATENCY-1, state<=BUSY.
  - padv_i is ignored in IDLE.
- BUSY state:
  - core_valid_o<=0 after exactly one cycle.
  - The counter decrements once per cycle.
  - At edge T0+LATENCY+1 the counter is 0: data_o<=core_res_i, valid_o<=1, state<=DONE.
  - valid_i and padv_i are ignored in BUSY.
- DONE state:
  - data_o and valid_o are held indefinitely.
  - padv_i=1 at an edge: valid_o<=0, ready_o<=1, state<=IDLE. data_o retains its last value.
  - valid_i is ignored in DONE, including when valid_i coincides with padv_i. The operand must be re-presented once ready_o=1.
- Latency and throughput:
  - Accept to valid_o is LATENCY+1 cycles.
  - Minimum accept-to-accept spacing is LATENCY+3 cycles: padv_i at the first valid_o cycle, then one IDLE cycle.
- Operand hold: core_op_o is held for the whole transaction, so non-pipelined cores may sample it at any time.
- Holding valid_i: a valid_i held high across transactions is accepted once per IDLE entry.
- Reset mid-operation:
  - Returns to IDLE with reset values on the next edge.
  - The in-flight result is discarded.
  - No valid_o is ever produced for the aborted operand.
- Counter width: the counter is CW bits, must not wrap, and is compared for zero only.

Optional Feature:
- Macro: FU_WRAPPER_ERR_EN.
- With the macro defined:
  - Extra port err_o, out, 1 bit, reset 0.
  - err_o is sticky and cleared only by rst.
  - Set when valid_i=1 while ready_o=0.
  - Set when padv_i=1 while valid_o=0.
  - Protocol behaviour is otherwise unchanged; the offending input is still ignored.
- Without the macro: the err_o port and its logic are absent.

Test Plan:
- Basic transaction:
  - Setup: LATENCY=4, stub core with core_res_i = core_op_o+1 registered through a 4-deep pipe.
  - Stimulus: valid_i pulse with data_i=16'h3F80 at edge T0.
  - Required response: ready_o=0 from T0+1; core_valid_o high only in cycle T0..T0+1; valid_o=1 and data_o=16'h3F81 from edge T0+5, held 10 cycles without padv_i.
- Advance:
  - Stimulus: padv_i pulse at edge Tp in DONE.
  - Required response: valid_o=0 and ready_o=1 from Tp+1; data_o stays 16'h3F81.
- Back-to-back sweep:
  - Stimulus: 256 operands 16'h8000..16'h80FF, each presented on ready_o, padv_i one cycle after valid_o.
  - Required response: each data_o equals operand+1; spacing exactly LATENCY+3 cycles; no drops or duplicates.
- Ignored inputs:
  - Stimulus: valid_i=1 with data_i=16'hFFFF during BUSY, then valid_i and padv_i together in DONE.
  - Required response: core_op_o unchanged; exactly one transaction completes; return to IDLE; no new launch until ready_o is seen.
- Reset mid-operation:
  - Stimulus: rst=1 at edge T0+2 of a transaction.
  - Required response: next edge ready_o=1, valid_o=0, data_o=0; valid_o never rises for the aborted operand.
- Error flag (FU_WRAPPER_ERR_EN):
  - Stimulus: padv_i in IDLE.
  - Required response: err_o=1 next cycle and stays 1 through further legal transactions until rst.
  - Without the macro: bench confirms the port is absent.
